// File: rtl/pattern_sequencer_pkg.sv
// Shared constants for the pattern sequencer and the pattern buffer bank:
// register addresses, field range, sequence entry layout and FSM states.
package pattern_sequencer_pkg;

  localparam int SEQ1ADR    = 0;
  localparam int SEQ2ADR    = 1;
  localparam int SEQCTRLADR = 2;

  localparam int FIRST_FIELD = 3;
  localparam int LAST_FIELD  = 26;
  localparam int NSTEPS      = 4;

  localparam int VALID_BIT = 3;
  localparam int BUF_MSB   = 2;

  localparam logic [4:0] FIRST_FP = 5'(FIRST_FIELD);
  localparam logic [4:0] LAST_FP  = 5'(LAST_FIELD);

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_PLAY  = 3'd2;
  localparam state_t S_NEXT  = 3'd3;
  localparam state_t S_DRAIN = 3'd4;

  typedef struct packed {
    logic             valid;
    logic [BUF_MSB:0] buf_sel;
  } seq_entry_t;

  // Steps are packed as 4-bit nibbles, step 0 in the low nibble of SEQ1.
  function automatic seq_entry_t get_entry(input logic [15:0] seq, input logic [1:0] step);
    return seq_entry_t'(seq[{step, 2'b00} +: 4]);
  endfunction

endpackage

// File: rtl/pattern_sequencer_out.sv
// Output stage of the pattern stream: byte plus last flag with valid/ready
// hold logic. A new byte may enter whenever the slot is empty or draining.
module pat_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load_req,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_ready,
  output logic       o_load_en,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last
);

  logic [7:0] r_data;
  logic       r_valid;
  logic       r_last;
  logic       w_load;

  assign o_load_en = !r_valid || i_ready;
  assign w_load    = i_load_req && o_load_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'd0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/pattern_sequencer.sv
// Walks the snapshotted step list, sweeping each selected buffer's pattern
// fields into a valid/ready byte stream.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seq1,
  input  logic [7:0] seq2,
  input  logic [7:0] seqctrl,
  input  logic [7:0] field_byte,
  output logic [2:0] bufp,
  output logic [4:0] fieldp,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  state_t      r_state;
  logic [1:0]  r_step;
  logic [15:0] r_seq;
  logic        r_loop;
  logic [2:0]  r_bufp;
  logic [4:0]  r_fieldp;
  logic        r_done;

  logic        w_run;
  logic        w_load_en;
  logic        w_load_req;
  logic        w_load;
  logic [1:0]  w_step_nx;
  logic        w_wrap;
  logic        w_unused_ctrl;
  seq_entry_t  w_entry0_live;
  seq_entry_t  w_entry_nx;
  seq_entry_t  w_entry0;

  assign w_run         = seqctrl[0];
  assign w_unused_ctrl = ^seqctrl[7:2];

  assign w_entry0_live = get_entry({seq2, seq1}, 2'd0);
  assign w_entry0      = get_entry(r_seq, 2'd0);
  assign w_step_nx     = r_step + 2'd1;
  assign w_wrap        = (r_step == 2'(NSTEPS - 1));
  assign w_entry_nx    = get_entry(r_seq, w_step_nx);

  assign w_load_req = (r_state == S_PLAY) && w_run;
  assign w_load     = w_load_req && w_load_en;

  // Running sequence is frozen at LOAD so later register writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_seq  <= {seq2, seq1};
      r_loop <= seqctrl[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_step   <= 2'd0;
      r_bufp   <= 3'd0;
      r_fieldp <= FIRST_FP;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_run) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_step <= 2'd0;
          if (!w_run) begin
            r_state <= S_DRAIN;
          end else if (!w_entry0_live.valid) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_bufp   <= w_entry0_live.buf_sel;
            r_fieldp <= FIRST_FP;
            r_state  <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!w_run) begin
            r_state <= S_DRAIN;
          end else if (w_load) begin
            if (r_fieldp == LAST_FP) r_state <= S_NEXT;
            else                     r_fieldp <= r_fieldp + 5'd1;
          end
        end
        S_NEXT: begin
          r_step <= w_step_nx;
          if (!w_run) begin
            r_state <= S_DRAIN;
          end else if (!w_wrap && w_entry_nx.valid) begin
            r_bufp   <= w_entry_nx.buf_sel;
            r_fieldp <= FIRST_FP;
            r_state  <= S_PLAY;
          end else if (r_loop && w_entry0.valid) begin
            // Looping restarts at step 0 without revisiting LOAD, keeping the snapshot.
            r_step   <= 2'd0;
            r_bufp   <= w_entry0.buf_sel;
            r_fieldp <= FIRST_FP;
            r_state  <= S_PLAY;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!out_valid || out_ready) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  pat_out_reg u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load_req (w_load_req),
    .i_data     (field_byte),
    .i_last     (r_fieldp == LAST_FP),
    .i_ready    (out_ready),
    .o_load_en  (w_load_en),
    .o_data     (out_data),
    .o_valid    (out_valid),
    .o_last     (out_last)
  );

  assign bufp   = r_bufp;
  assign fieldp = r_fieldp;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;

endmodule
